// File: rtl/led_pulse.sv
// Event-queued LED/buzzer pulse generator: IDLE -> ON -> GAP, with up to 15 queued events.
// Optional dimming during ON is enabled by defining LED_DIM_EN.
module led_pulse #(
  parameter int ON_CYCLES  = 50000000,
  parameter int GAP_CYCLES = 25000000,
  parameter int DIM_DUTY   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  output logic       out,
  output logic       busy,
  output logic [3:0] pending,
  output logic       overflow
);

  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [4:0]    DUTY     = 5'(DIM_DUTY);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   count, countNext;
  logic [3:0]      pendingNext;
  logic            overflowNext;
  logic            trigPrev;
  logic            armed;
  logic            evt;
  logic            onLevel;

  always_comb begin
    // armed masks the first cycle after reset so a trig held through release is not an edge
    evt          = trig & ~trigPrev & armed;
    stateNext    = state;
    countNext    = count;
    pendingNext  = pending;
    overflowNext = 1'b0;
    case (state)
      IDLE: begin
        if (evt) begin
          stateNext = ON;
          countNext = ON_LOAD;
        end
      end
      ON: begin
        if (count == '0) begin
          stateNext = GAP;
          countNext = GAP_LOAD;
        end else begin
          countNext = count - 1'b1;
        end
        if (evt) begin
          if (pending == 4'd15) overflowNext = 1'b1;
          else                  pendingNext  = pending + 4'd1;
        end
      end
      GAP: begin
        if (count == '0) begin
          // a same-cycle event replaces the dequeued one, so pending holds
          if (pending != 4'd0 || evt) begin
            stateNext = ON;
            countNext = ON_LOAD;
            if (!evt) pendingNext = pending - 4'd1;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          countNext = count - 1'b1;
          if (evt) begin
            if (pending == 4'd15) overflowNext = 1'b1;
            else                  pendingNext  = pending + 4'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef LED_DIM_EN
  logic [3:0] phase;
  logic [3:0] phaseNext;

  assign phaseNext = phase + 4'd1;
  assign onLevel   = ({1'b0, phaseNext} < DUTY);

  always_ff @(posedge clk) begin
    if (!rst_n) phase <= 4'd0;
    else        phase <= phaseNext;
  end
`else
  logic unusedDuty;

  assign unusedDuty = ^DUTY;
  assign onLevel    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      pending  <= 4'd0;
      trigPrev <= 1'b0;
      armed    <= 1'b0;
      out      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      pending  <= pendingNext;
      trigPrev <= trig;
      armed    <= 1'b1;
      out      <= (stateNext == ON) && onLevel;
      busy     <= (stateNext != IDLE);
      overflow <= overflowNext;
    end
  end

endmodule
